// File: rtl/multi_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM encoding, nibble
// geometry, per-index accumulator shift table and nibble-pair selection.
package multi_pkg;

    localparam int NUM_PP = 4;
    localparam int NIB_W  = 4;
    localparam int IDX_W  = 2;
    localparam int ACC_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] PP_SHIFT [NUM_PP] = '{4'd0, 4'd4, 4'd4, 4'd8};

    function automatic logic [3:0] pp_shift(input logic [IDX_W-1:0] idx);
        return PP_SHIFT[idx];
    endfunction

    // idx[1] picks the A nibble, idx[0] the B nibble: k0 lo/lo, k1 lo/hi, k2 hi/lo, k3 hi/hi
    function automatic logic [2*NIB_W-1:0] pp_nibbles(input logic [IDX_W-1:0] idx,
                                                       input logic [7:0]       a,
                                                       input logic [7:0]       b);
        logic [NIB_W-1:0] na;
        logic [NIB_W-1:0] nb;
        na = idx[1] ? a[7:4] : a[3:0];
        nb = idx[0] ? b[7:4] : b[3:0];
        return {na, nb};
    endfunction

endpackage

// File: rtl/multi_pp_shift_acc.sv
// Delays each issued partial-product index by PP_LATENCY cycles so the returning
// pp_in can be shifted into the 16-bit accumulator under the right weight.
module multi_pp_shift_acc
    import multi_pkg::*;
#(
    parameter int PP_LATENCY = 1
)
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 i_acc_clr,
    input  logic                 i_issue_vld,
    input  logic [IDX_W-1:0]     i_issue_idx,
    input  logic [2*NIB_W-1:0]   i_pp_in,
    output logic [ACC_W-1:0]     o_acc_next,
    output logic                 o_last
);

    logic [PP_LATENCY-1:0] r_vld;
    logic [IDX_W-1:0]      r_idx [PP_LATENCY];
    logic [ACC_W-1:0]      r_acc;
    logic                  w_tail_vld;
    logic [IDX_W-1:0]      w_tail_idx;
    logic [ACC_W-1:0]      w_term;

    // Index pipeline; clr flushes any samples still in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            r_vld <= '0;
            for (int i = 0; i < PP_LATENCY; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_issue_vld;
            r_idx[0] <= i_issue_idx;
            for (int i = 1; i < PP_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign w_tail_vld = r_vld[PP_LATENCY-1];
    assign w_tail_idx = r_idx[PP_LATENCY-1];
    assign o_last     = w_tail_vld && (w_tail_idx == 2'd3);

    // Weighted accumulate of the sample that matches the pipeline tail
    always_comb begin
        w_term = {8'd0, i_pp_in} << pp_shift(w_tail_idx);
        if (i_acc_clr) begin
            o_acc_next = 16'd0;
        end else if (w_tail_vld) begin
            o_acc_next = r_acc + w_term;
        end else begin
            o_acc_next = r_acc;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_acc <= 16'd0;
        end else begin
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/multi_8_8_seq.sv
// Sequential 8x8 unsigned multiplier built on an external registered 4x4 stage.
// Optional zero-operand shortcut enabled by defining MULTI_8_8_ZSKIP_EN.
module multi_8_8_seq
    import multi_pkg::*;
#(
    parameter int PP_LATENCY = 1
)
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [7:0]           A,
    input  logic [7:0]           B,
    output logic [NIB_W-1:0]     pp_a,
    output logic [NIB_W-1:0]     pp_b,
    input  logic [2*NIB_W-1:0]   pp_in,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     P
);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_next;
    logic [7:0]         r_a;
    logic [7:0]         r_b;
    logic [NIB_W-1:0]   r_pp_a;
    logic [NIB_W-1:0]   r_pp_b;
    logic [2*NIB_W-1:0] w_pp_next;
    logic               r_busy;
    logic               r_done;
    logic [ACC_W-1:0]   r_p;
    logic               w_accept;
    logic               w_zskip;
    logic               w_last;
    logic [ACC_W-1:0]   w_acc_next;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef MULTI_8_8_ZSKIP_EN
    assign w_zskip = (A == 8'd0) || (B == 8'd0);
`else
    assign w_zskip = 1'b0;
`endif

    multi_pp_shift_acc #(
        .PP_LATENCY (PP_LATENCY)
    ) u_acc (
        .clk         (clk),
        .clr         (clr),
        .i_acc_clr   (w_accept),
        .i_issue_vld (r_state == ST_ISSUE),
        .i_issue_idx (r_cnt),
        .i_pp_in     (pp_in),
        .o_acc_next  (w_acc_next),
        .o_last      (w_last)
    );

    // Next-state, issue counter and next nibble pair
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = 2'd0;
        w_pp_next    = 8'd0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_next = w_zskip ? ST_DONE : ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_cnt_next = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Operands are not latched yet on the accept cycle, so k0 comes from the ports
        if (w_state_next == ST_ISSUE) begin
            if (w_accept) begin
                w_pp_next = pp_nibbles(2'd0, A, B);
            end else begin
                w_pp_next = pp_nibbles(w_cnt_next, r_a, r_b);
            end
        end else begin
            w_pp_next = 8'd0;
        end
    end

    // State and registered outputs; P only moves when entering DONE
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_pp_a  <= 4'd0;
            r_pp_b  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_a <= A;
                r_b <= B;
            end
            r_pp_a <= w_pp_next[7:4];
            r_pp_b <= w_pp_next[3:0];
            r_busy <= (w_state_next == ST_ISSUE) || (w_state_next == ST_DRAIN);
            r_done <= (w_state_next == ST_DONE);
            if (w_state_next == ST_DONE) begin
                r_p <= w_acc_next;
            end
        end
    end

    assign pp_a = r_pp_a;
    assign pp_b = r_pp_b;
    assign busy = r_busy;
    assign done = r_done;
    assign P    = r_p;

endmodule

// File: tb/tb_multi_8_8_seq.sv
// Self-checking bench: multi_8_8_seq paired with a registered 4x4 product stage.
module tb_multi_8_8_seq;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  pp_a;
    logic [3:0]  pp_b;
    logic [7:0]  pp_in;
    logic        busy;
    logic        done;
    logic [15:0] P;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_8_8_seq #(.PP_LATENCY(LAT)) dut (
        .clk(clk), .clr(clr), .start(start), .A(A), .B(B),
        .pp_a(pp_a), .pp_b(pp_b), .pp_in(pp_in),
        .busy(busy), .done(done), .P(P)
    );

    always_ff @(posedge clk) begin
        pp_in <= {4'd0, pp_a} * {4'd0, pp_b};
    end

    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MULTI_8_8_ZSKIP_EN
        if (a == 8'd0 || b == 8'd0) return 1;
`endif
        return 5 + LAT;
    endfunction

    function automatic logic [3:0] exp_nib_a(input logic [7:0] a, input int k);
        return (k >= 2) ? a[7:4] : a[3:0];
    endfunction

    function automatic logic [3:0] exp_nib_b(input logic [7:0] b, input int k);
        return (k == 1 || k == 3) ? b[7:4] : b[3:0];
    endfunction

    // One multiply from a negedge with start low; observations returned to caller
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                          output logic [15:0] p, output int bad_busy, output int bad_pp,
                          output int bad_partial, output logic pulse_after);
        logic [15:0] prev;
        lat = -1; p = 16'd0; bad_busy = 0; bad_pp = 0; bad_partial = 0; pulse_after = 1'b1;
        prev = P;
        A = a; B = b; start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = n; p = P;
                if (busy !== 1'b0) bad_busy++;
                if (pp_a !== 4'd0 || pp_b !== 4'd0) bad_pp++;
                break;
            end
            if (busy !== 1'b1) bad_busy++;
            if (P !== prev) bad_partial++;
            if (n <= 4) begin
                if (pp_a !== exp_nib_a(a, n - 1) || pp_b !== exp_nib_b(b, n - 1)) bad_pp++;
            end else if (pp_a !== 4'd0 || pp_b !== 4'd0) begin
                bad_pp++;
            end
        end
        @(negedge clk);
        pulse_after = done;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b1; A = 8'($urandom); B = 8'($urandom);
        repeat (3) @(negedge clk);
        checks++; if (P !== 16'd0) begin errors++; $display("FAIL reset_P got %h want 0000", P); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (pp_a !== 4'd0) begin errors++; $display("FAIL reset_pp_a got %h want 0", pp_a); end
        checks++; if (pp_b !== 4'd0) begin errors++; $display("FAIL reset_pp_b got %h want 0", pp_b); end
        clr = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0]  ta [3] = '{8'h12, 8'hFF, 8'h01};
        logic [7:0]  tb [3] = '{8'h34, 8'hFF, 8'h80};
        logic [15:0] tp [3] = '{16'h03A8, 16'hFE01, 16'h0080};
        int lat, bb, bp, bq; logic [15:0] p; logic pa;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], lat, p, bb, bp, bq, pa);
            checks++; if (p !== tp[i]) begin errors++; $display("FAIL directed_P a=%h b=%h got %h want %h", ta[i], tb[i], p, tp[i]); end
            checks++; if (lat != 6) begin errors++; $display("FAIL directed_latency a=%h b=%h got %0d want 6", ta[i], tb[i], lat); end
            checks++; if (bb != 0) begin errors++; $display("FAIL directed_busy a=%h got %0d bad cycles want 0", ta[i], bb); end
            checks++; if (bp != 0) begin errors++; $display("FAIL directed_pp a=%h got %0d bad cycles want 0", ta[i], bp); end
            checks++; if (bq != 0) begin errors++; $display("FAIL directed_partial a=%h got %0d bad cycles want 0", ta[i], bq); end
            checks++; if (pa !== 1'b0) begin errors++; $display("FAIL directed_pulse a=%h got %b want 0", ta[i], pa); end
        end
    endtask

    task automatic test_random();
        int lat, bb, bp, bq; logic [15:0] p, ep; logic pa; logic [7:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 7 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
            ep = 16'(a) * 16'(b);
            run_op(a, b, lat, p, bb, bp, bq, pa);
            checks++; if (p !== ep) begin errors++; $display("FAIL random_P a=%h b=%h got %h want %h", a, b, p, ep); end
            checks++; if (lat != exp_lat(a, b)) begin errors++; $display("FAIL random_latency a=%h b=%h got %0d want %0d", a, b, lat, exp_lat(a, b)); end
            checks++; if (bb + bp + bq != 0) begin errors++; $display("FAIL random_cycle a=%h b=%h got busy/pp/partial %0d/%0d/%0d want 0/0/0", a, b, bb, bp, bq); end
            checks++; if (pa !== 1'b0) begin errors++; $display("FAIL random_pulse a=%h b=%h got %b want 0", a, b, pa); end
        end
    endtask

    task automatic test_zero_operand();
        int lat, bb, bp, bq; logic [15:0] p; logic pa;
        run_op(8'h00, 8'h7F, lat, p, bb, bp, bq, pa);
        checks++; if (p !== 16'd0) begin errors++; $display("FAIL zero_P got %h want 0000", p); end
        checks++; if (lat != exp_lat(8'h00, 8'h7F)) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, exp_lat(8'h00, 8'h7F)); end
        checks++; if (pa !== 1'b0) begin errors++; $display("FAIL zero_pulse got %b want 0", pa); end
    endtask

    task automatic test_busy_ignore();
        int ndone = 0, dn = -1; logic [15:0] dp = 16'd0;
        A = 8'h12; B = 8'h34; start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (dn < 0) begin dn = n; dp = P; end
            end
            if (n == 2) begin start = 1'b1; A = 8'h03; B = 8'h03; end
            if (n == 3) start = 1'b0;
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        checks++; if (dn != 5 + LAT) begin errors++; $display("FAIL ignore_latency got %0d want %0d", dn, 5 + LAT); end
        checks++; if (dp !== 16'h03A8) begin errors++; $display("FAIL ignore_P got %h want 03a8", dp); end
    endtask

    task automatic test_back_to_back();
        int n1 = -1, m2 = -1, bq = 0; logic b1 = 1'b0; logic [15:0] p1 = 16'd0, p2 = 16'd0;
        A = 8'h12; B = 8'h34; start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done === 1'b1) begin
                n1 = n; p1 = P;
                A = 8'h10; B = 8'h10; start = 1'b1;
                break;
            end
        end
        for (int m = 1; m <= 40; m++) begin
            @(negedge clk);
            if (m == 1) begin start = 1'b0; b1 = busy; end
            if (done === 1'b1) begin m2 = m; p2 = P; break; end
            if (P !== p1) bq++;
        end
        start = 1'b0;
        @(negedge clk);
        checks++; if (n1 != 5 + LAT) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", n1, 5 + LAT); end
        checks++; if (p1 !== 16'h03A8) begin errors++; $display("FAIL b2b_first_P got %h want 03a8", p1); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL b2b_busy_next got %b want 1", b1); end
        checks++; if (m2 != 5 + LAT) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", m2, 5 + LAT); end
        checks++; if (p2 !== 16'h0100) begin errors++; $display("FAIL b2b_second_P got %h want 0100", p2); end
        checks++; if (bq != 0) begin errors++; $display("FAIL b2b_partial got %0d bad cycles want 0", bq); end
    endtask

    task automatic test_clr_abort();
        int ndone = 0, lat, bb, bp, bq; logic [15:0] p; logic pa;
        A = 8'hAA; B = 8'h55; start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done === 1'b1) ndone++;
            if (n == 3) clr = 1'b1;
            if (n == 4) clr = 1'b0;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL clr_done_count got %0d want 0", ndone); end
        checks++; if (P !== 16'd0) begin errors++; $display("FAIL clr_P got %h want 0000", P); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
        run_op(8'h02, 8'h03, lat, p, bb, bp, bq, pa);
        checks++; if (p !== 16'h0006) begin errors++; $display("FAIL clr_next_P got %h want 0006", p); end
        checks++; if (lat != 5 + LAT) begin errors++; $display("FAIL clr_next_latency got %0d want %0d", lat, 5 + LAT); end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; A = 8'd0; B = 8'd0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_zero_operand();
        test_busy_ignore();
        test_back_to_back();
        test_clr_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multi_8_8_seq.md
MULTI_8_8_SEQ -- requirements
Module: multi_8_8_seq

Interface
REQ-001 SHALL have parameter PP_LATENCY, default 1: clock cycles from pp_a/pp_b presented to matching pp_in valid; legal range 1..3.
REQ-002 SHALL have port clk  in  1  rising-edge clock, sole clock.
REQ-003 SHALL have port clr  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  in  1  request; A/B sampled when accepted.
REQ-005 SHALL have port A  in  8  multiplicand, unsigned.
REQ-006 SHALL have port B  in  8  multiplier, unsigned.
REQ-007 SHALL have port pp_a  out  4  nibble to the external 4x4 partial-product stage.
REQ-008 SHALL have port pp_b  out  4  nibble to the external 4x4 partial-product stage.
REQ-009 SHALL have port pp_in  in  8  registered 4x4 product returned by that stage.
REQ-010 SHALL have port busy  out  1  high while a multiply is in flight.
REQ-011 SHALL have port done  out  1  one-cycle pulse; P valid.
REQ-012 SHALL have port P  out  16  product A*B.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, DRAIN, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance SHALL latch A and B, clear the accumulator, go to ISSUE.
REQ-015 SHALL ignore start in ISSUE or DRAIN; latched operands and result unaffected.
REQ-016 ISSUE SHALL last exactly 4 cycles, presenting in order: k0 {A[3:0],B[3:0]}, k1 {A[3:0],B[7:4]}, k2 {A[7:4],B[3:0]}, k3 {A[7:4],B[7:4]}.
REQ-017 SHALL sample pp_in for index k exactly PP_LATENCY cycles after pp_a/pp_b for k were presented, and add it to the 16-bit accumulator shifted left by 0 (k0), 4 (k1, k2), 8 (k3).
REQ-018 Accumulator SHALL be 16 bits wide; the maximum sum 0xFE01 never overflows, no carry out.
REQ-019 DRAIN SHALL last PP_LATENCY cycles, until the k3 sample is accumulated; then DONE.
REQ-020 DONE SHALL last one cycle: done=1, P=final accumulator, then IDLE unless start accepted.
REQ-021 Latency: start high in cycle 0 -> done high in cycle 5+PP_LATENCY (cycle 6 at default).
REQ-022 P SHALL hold the last result until the next DONE; it SHALL NOT show partial sums.
REQ-023 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE and DONE.
REQ-024 pp_a/pp_b SHALL be 0 outside ISSUE.
REQ-025 Start accepted in DONE SHALL give back-to-back operation: ISSUE starts next cycle, no idle gap.

Reset
REQ-026 clr=1 SHALL force IDLE, P=0, done=0, busy=0, pp_a=pp_b=0, accumulator=0, counters=0.
REQ-027 clr SHALL take priority over start; clr mid-operation SHALL abort with no done pulse, and pp_in samples still in flight SHALL be discarded.

Configuration
REQ-028 Macro MULTI_8_8_ZSKIP_EN, when defined: an accepted start with A==0 or B==0 SHALL skip ISSUE/DRAIN, go directly to DONE next cycle with P=0 (done in cycle 1).
REQ-029 Without MULTI_8_8_ZSKIP_EN, zero operands SHALL take the full REQ-021 latency and yield P=0.

Structure
REQ-030 Shared package multi_pkg SHALL hold the FSM state encoding, NUM_PP=4, NIB_W=4, and the per-index shift table {0,4,4,8}.
REQ-031 Sub-module multi_pp_shift_acc SHALL contain the delayed index pipeline (PP_LATENCY stages), shift selection and the 16-bit accumulator; the FSM stays in the top module.
REQ-032 The 4x4 partial-product stage SHALL be instantiated outside this block.

Verification
REQ-033 Bench pairs the block with the registered 4x4 stage, PP_LATENCY=1: A=0x12, B=0x34 at cycle 0 -> done cycle 6, P=0x03A8.
REQ-034 A=0xFF, B=0xFF -> P=0xFE01; A=0x01, B=0x80 -> P=0x0080.
REQ-035 Second start during busy (A=0x03,B=0x03) -> ignored; first result delivered unchanged; one done.
REQ-036 Start in DONE cycle with A=0x10,B=0x10 -> ISSUE next cycle, second done 6 cycles later, P=0x0100.
REQ-037 clr in cycle 3 of A=0xAA,B=0x55 -> no done, P=0, busy=0; a following start A=0x02,B=0x03 -> P=0x0006.
REQ-038 A=0x00, B=0x7F: with MULTI_8_8_ZSKIP_EN -> done cycle 1, P=0; without it -> done cycle 6, P=0.
